// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes engine.
// Takes one 128-bit state over a valid/ready handshake and applies the inverse
// S-box to all 16 bytes, BYTES_PER_CYCLE bytes per cycle, with the S-box
// instances reused across cycles. The result is presented over valid/ready.
// Byte i of a state sits at bits [127-8*i -: 8]; byte 0 is the MSB.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   in_valid  - in_state is valid
//   in_ready  - engine idle; in_valid && in_ready accepts in_state
//   in_state  - 128-bit input state
//   out_valid - out_state holds a complete result
//   out_ready - consumer takes out_state when out_valid && out_ready
//   out_state - 128-bit result, byte i = InvSbox(input byte i)
//   busy      - a block is being processed or held for output
module inv_sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4,
    parameter int unsigned PIPE            = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NBYTES = 16;
    localparam int unsigned BPC    = (BYTES_PER_CYCLE == 0) ? 1 : BYTES_PER_CYCLE;
    localparam int unsigned GRPS   = NBYTES / BPC;
    localparam int unsigned GW     = 8 * BPC;
    localparam int unsigned CW     = (GRPS > 1) ? $clog2(GRPS) : 1;

    localparam logic [127:0] LANE_MASK = 128'({GW{1'b1}});

    // FIPS-197 InvSbox, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Parameter legality: the byte count per cycle must divide the block.
    if (BYTES_PER_CYCLE == 0 || (NBYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
    if (PIPE > 1) begin : g_bad_pipe
        $error("inv_sub_bytes_iter: PIPE must be 0 or 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Bit offset of group g's least significant bit (group 0 holds the MSBs).
    function automatic logic [7:0] grp_shift(input logic [CW-1:0] g);
        return 8'(GW * (int'(GRPS) - 1 - int'(g)));
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   out_q, out_d;

    logic [GW-1:0]  grp_in;
    logic [GW-1:0]  grp_sb;
    logic           wb_en;
    logic [CW-1:0]  wb_grp;
    logic [GW-1:0]  wb_data;
    logic [7:0]     wb_sh;

    // Select the current group out of the work register.
    assign grp_in = GW'(work_q >> grp_shift(cnt_q));

    // Shared inverse S-box lanes.
    for (genvar b = 0; b < int'(BPC); b++) begin : g_lane
        assign grp_sb[GW-1-8*b -: 8] = inv_sbox(grp_in[GW-1-8*b -: 8]);
    end

    // Write-back source: direct from the S-boxes, or one cycle later from a pipe register.
    if (PIPE != 0) begin : g_pipe
        logic          pipe_vld_q, pipe_vld_d;
        logic [CW-1:0] pipe_grp_q, pipe_grp_d;
        logic [GW-1:0] pipe_dat_q, pipe_dat_d;

        always_comb begin
            pipe_vld_d = (state_q == S_RUN);
            pipe_grp_d = pipe_grp_q;
            pipe_dat_d = pipe_dat_q;
            if (state_q == S_RUN) begin
                pipe_grp_d = cnt_q;
                pipe_dat_d = grp_sb;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_vld_q <= 1'b0;
                pipe_grp_q <= '0;
                pipe_dat_q <= '0;
            end else begin
                pipe_vld_q <= pipe_vld_d;
                pipe_grp_q <= pipe_grp_d;
                pipe_dat_q <= pipe_dat_d;
            end
        end

        assign wb_en   = pipe_vld_q;
        assign wb_grp  = pipe_grp_q;
        assign wb_data = pipe_dat_q;
    end else begin : g_nopipe
        assign wb_en   = (state_q == S_RUN);
        assign wb_grp  = cnt_q;
        assign wb_data = grp_sb;
    end

    assign wb_sh = grp_shift(wb_grp);

    // Next-state, counter, work and result register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;

        if (wb_en) begin
            out_d = (out_q & ~(LANE_MASK << wb_sh)) | (128'(wb_data) << wb_sh);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(GRPS - 1)) begin
                    cnt_d   = '0;
                    state_d = (PIPE != 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    // Handshake and status flags decode directly from the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_state = out_q;

endmodule
